axi4_slave_mem_responder: RTL and testbench

//  AXI4 slave responder: the target end of the CPU-side AXI4 master BFM link.

---
 rtl/axi4_slave_mem_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi4_slave_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave memory responder: independent write and read burst FSMs answering from a
// register-array memory. The bus structs live in venus_soc_pkg, declared here as well.

package venus_soc_pkg;
    localparam int unsigned AXI_DATA_W = 512;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_ID_W   = 7;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ID_W-1:0]     arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arvalid;
        logic                    rready;
    } axi_req_t;

    typedef struct packed {
        logic                    awready;
        logic                    wready;
        logic [AXI_ID_W-1:0]     bid;
        logic [1:0]              bresp;
        logic                    bvalid;
        logic                    arready;
        logic [AXI_ID_W-1:0]     rid;
        logic [AXI_DATA_W-1:0]   rdata;
        logic [1:0]              rresp;
        logic                    rlast;
        logic                    rvalid;
    } axi_resp_t;
endpackage

module axi4_slave_mem_responder
    import venus_soc_pkg::*;
#(
    parameter int unsigned                  DATA_BUS_WIDTH    = AXI_DATA_W,
    parameter int unsigned                  ADDRESS_BUS_WIDTH = AXI_ADDR_W,
    parameter int unsigned                  ID_BUS_WIDTH      = AXI_ID_W,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] BASE_ADDR         = '0,
    parameter int unsigned                  DEPTH             = 256
) (
    input  logic      clk,
    input  logic      rst,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o
);

    localparam int unsigned DBYTES = DATA_BUS_WIDTH / 8;
    localparam int unsigned OFFS   = $clog2(DBYTES);
    localparam int unsigned IDXW   = $clog2(DEPTH);
    localparam int unsigned AW1    = ADDRESS_BUS_WIDTH + 1;
    // One spare address bit so an INCR burst running off the top never aliases back in range.
    localparam logic [AW1-1:0] BASE_X  = AW1'(BASE_ADDR);
    localparam logic [AW1-1:0] END_X   = BASE_X + AW1'(DEPTH * DBYTES);
    localparam logic [AW1-1:0] STEP_X  = AW1'(DBYTES);
    localparam logic [2:0]     SIZE_OK = 3'(OFFS);
    localparam logic [1:0]     BURST_FIXED = 2'b00;
    localparam logic [1:0]     BURST_WRAP  = 2'b10;
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    function automatic logic f_in_range(input logic [AW1-1:0] a);
        return (a >= BASE_X) && (a < END_X);
    endfunction

    function automatic logic [IDXW-1:0] f_idx(input logic [AW1-1:0] a);
        return IDXW'((a - BASE_X) >> OFFS);
    endfunction

    logic [DATA_BUS_WIDTH-1:0] r_mem [DEPTH];

    // Write path
    w_state_e                r_wstate;
    logic                    r_awready, r_wready, r_bvalid;
    logic [1:0]              r_bresp;
    logic [ID_BUS_WIDTH-1:0] r_bid;
    logic [AW1-1:0]          r_waddr;
    logic [7:0]              r_awlen, r_wbeat;
    logic                    r_wfixed, r_wstat_err, r_werr;

    logic            w_wfire, w_wlast_beat, w_wbeat_err, w_wen;
    logic [IDXW-1:0] w_widx;

    assign w_wfire      = r_wready & axi_req_i.wvalid;
    assign w_wlast_beat = (r_wbeat == r_awlen);
    assign w_wbeat_err  = r_wstat_err | ~f_in_range(r_waddr) | (axi_req_i.wlast ^ w_wlast_beat);
    assign w_wen        = w_wfire & ~w_wbeat_err;
    assign w_widx       = f_idx(r_waddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate    <= WIdle;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_bid       <= '0;
            r_waddr     <= '0;
            r_awlen     <= '0;
            r_wbeat     <= '0;
            r_wfixed    <= 1'b0;
            r_wstat_err <= 1'b0;
            r_werr      <= 1'b0;
        end else begin
            unique case (r_wstate)
                WIdle: begin
                    if (!r_awready) begin
                        r_awready <= 1'b1;
                    end else if (axi_req_i.awvalid) begin
                        r_bid       <= axi_req_i.awid;
                        r_waddr     <= {1'b0, axi_req_i.awaddr};
                        r_awlen     <= axi_req_i.awlen;
                        r_wbeat     <= '0;
                        r_wfixed    <= (axi_req_i.awburst == BURST_FIXED);
                        r_wstat_err <= (axi_req_i.awburst == BURST_WRAP) |
                                       (axi_req_i.awsize != SIZE_OK);
                        r_werr      <= 1'b0;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_wstate    <= WData;
                    end
                end
                WData: begin
                    if (w_wfire) begin
                        r_werr  <= r_werr | w_wbeat_err;
                        r_wbeat <= r_wbeat + 8'd1;
                        if (!r_wfixed) r_waddr <= r_waddr + STEP_X;
                        // Burst length comes from awlen alone; a stray or missing wlast only errors.
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (axi_req_i.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= WIdle;
                    end
                end
                default: r_wstate <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wen) begin
            for (int i = 0; i < int'(DBYTES); i++) begin
                if (axi_req_i.wstrb[i]) r_mem[w_widx][8*i +: 8] <= axi_req_i.wdata[8*i +: 8];
            end
        end
    end

    // Read path
    r_state_e                  r_rstate;
    logic                      r_arready, r_rvalid, r_rlast;
    logic [1:0]                r_rresp;
    logic [DATA_BUS_WIDTH-1:0] r_rdata;
    logic [ID_BUS_WIDTH-1:0]   r_rid;
    logic [AW1-1:0]            r_raddr;
    logic [7:0]                r_arlen, r_rbeat;
    logic                      r_rfixed, r_rstat_err;

    logic                      w_ridle, w_rsel_stat, w_rsel_err;
    logic [AW1-1:0]            w_rsel_addr;
    logic [DATA_BUS_WIDTH-1:0] w_rsel_data;

    // Address/status of the beat about to be loaded: beat 0 from AR, later beats from r_raddr.
    assign w_ridle     = (r_rstate == RIdle);
    assign w_rsel_addr = w_ridle  ? {1'b0, axi_req_i.araddr} :
                         r_rfixed ? r_raddr : r_raddr + STEP_X;
    assign w_rsel_stat = w_ridle ? ((axi_req_i.arburst == BURST_WRAP) |
                                    (axi_req_i.arsize != SIZE_OK)) : r_rstat_err;
    assign w_rsel_err  = w_rsel_stat | ~f_in_range(w_rsel_addr);
    assign w_rsel_data = w_rsel_err ? '0 : r_mem[f_idx(w_rsel_addr)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate    <= RIdle;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_rid       <= '0;
            r_raddr     <= '0;
            r_arlen     <= '0;
            r_rbeat     <= '0;
            r_rfixed    <= 1'b0;
            r_rstat_err <= 1'b0;
        end else begin
            unique case (r_rstate)
                RIdle: begin
                    if (!r_arready) begin
                        r_arready <= 1'b1;
                    end else if (axi_req_i.arvalid) begin
                        r_rid       <= axi_req_i.arid;
                        r_arlen     <= axi_req_i.arlen;
                        r_rfixed    <= (axi_req_i.arburst == BURST_FIXED);
                        r_rstat_err <= w_rsel_stat;
                        r_raddr     <= w_rsel_addr;
                        r_rbeat     <= '0;
                        r_rvalid    <= 1'b1;
                        r_rdata     <= w_rsel_data;
                        r_rresp     <= w_rsel_err ? RESP_SLVERR : RESP_OKAY;
                        r_rlast     <= (axi_req_i.arlen == 8'd0);
                        r_arready   <= 1'b0;
                        r_rstate    <= RData;
                    end
                end
                RData: begin
                    if (axi_req_i.rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= RIdle;
                        end else begin
                            r_raddr <= w_rsel_addr;
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rdata <= w_rsel_data;
                            r_rresp <= w_rsel_err ? RESP_SLVERR : RESP_OKAY;
                            r_rlast <= ((r_rbeat + 8'd1) == r_arlen);
                        end
                    end
                end
                default: r_rstate <= RIdle;
            endcase
        end
    end

    always_comb begin
        axi_resp_o         = '0;
        axi_resp_o.awready = r_awready;
        axi_resp_o.wready  = r_wready;
        axi_resp_o.bid     = r_bid;
        axi_resp_o.bresp   = r_bresp;
        axi_resp_o.bvalid  = r_bvalid;
        axi_resp_o.arready = r_arready;
        axi_resp_o.rid     = r_rid;
        axi_resp_o.rdata   = r_rdata;
        axi_resp_o.rresp   = r_rresp;
        axi_resp_o.rlast   = r_rlast;
        axi_resp_o.rvalid  = r_rvalid;
    end

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Bench for axi4_slave_mem_responder: directed and random bursts checked against a
// word-array memory model evaluated from plain address arithmetic.

module tb_axi4_slave_mem_responder;
    import venus_soc_pkg::*;

    localparam int     DB    = 64;
    localparam int     DEPTH = 256;
    localparam longint BASE  = 0;
    localparam longint MEMB  = longint'(DEPTH) * DB;

    logic      clk = 1'b0;
    logic      rst;
    axi_req_t  req;
    axi_resp_t resp;

    int n_cmp = 0;
    int n_err = 0;

    logic [511:0] m_mem [DEPTH];
    logic [511:0] wq_data [$];
    logic [63:0]  wq_strb [$];
    logic         wq_last [$];

    always #5 clk = ~clk;

    axi4_slave_mem_responder #(
        .DATA_BUS_WIDTH   (512),
        .ADDRESS_BUS_WIDTH(32),
        .ID_BUS_WIDTH     (7),
        .BASE_ADDR        (32'h0000_0000),
        .DEPTH            (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic longint beat_addr(input longint a, input int b, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + longint'(b) * DB;
    endfunction

    function automatic bit beat_ok(input longint a, input logic [1:0] burst, input logic [2:0] size);
        return (burst != 2'b10) && (size == 3'd6) && (a >= BASE) && (a < BASE + MEMB);
    endfunction

    function automatic int idx_of(input longint a);
        return int'(((a - BASE) / DB) % DEPTH);
    endfunction

    // Queue up len+1 write beats; bad_beat >= 0 flips wlast on that beat.
    task automatic fill_w(input int len, input bit rnd_strb, input int bad_beat);
        wq_data.delete(); wq_strb.delete(); wq_last.delete();
        for (int b = 0; b <= len; b++) begin
            wq_data.push_back(rand512());
            wq_strb.push_back(rnd_strb ? {$urandom, $urandom} : {64{1'b1}});
            wq_last.push_back((b == len) ^ (b == bad_beat));
        end
    endtask

    task automatic axi_write(input logic [6:0] id, input longint addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size, input int stall,
                             input string tag);
        logic [1:0] exp_resp = 2'b00;
        int t;
        for (int b = 0; b <= len; b++) begin
            longint a = beat_addr(addr, b, burst);
            if (beat_ok(a, burst, size) && (wq_last[b] == (b == len))) begin
                for (int k = 0; k < DB; k++)
                    if (wq_strb[b][k]) m_mem[idx_of(a)][8*k +: 8] = wq_data[b][8*k +: 8];
            end else begin
                exp_resp = 2'b10;
            end
        end
        req.awid = id; req.awaddr = addr[31:0]; req.awlen = 8'(len);
        req.awburst = burst; req.awsize = size; req.awvalid = 1'b1;
        t = 0;
        while (!resp.awready && t < 20) begin step(); t++; end
        chk({tag, "/awready"}, resp.awready, 1'b1);
        step();
        req.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            req.wdata = wq_data[b]; req.wstrb = wq_strb[b]; req.wlast = wq_last[b];
            req.wvalid = 1'b1;
            t = 0;
            while (!resp.wready && t < 20) begin step(); t++; end
            chk({tag, "/wready"}, resp.wready, 1'b1);
            step();
        end
        req.wvalid = 1'b0; req.wlast = 1'b0;
        t = 0;
        while (!resp.bvalid && t < 20) begin step(); t++; end
        chk({tag, "/bvalid"}, resp.bvalid, 1'b1);
        chk({tag, "/bresp"}, resp.bresp, exp_resp);
        chk({tag, "/bid"}, resp.bid, id);
        for (int s = 0; s < stall; s++) begin
            step();
            chk({tag, "/bvalid_hold"}, resp.bvalid, 1'b1);
            chk({tag, "/bresp_hold"}, resp.bresp, exp_resp);
        end
        req.bready = 1'b1;
        step();
        req.bready = 1'b0;
        chk({tag, "/bvalid_drop"}, resp.bvalid, 1'b0);
        chk({tag, "/awready_back"}, resp.awready, 1'b1);
    endtask

    // rmode: 0 always ready, 1 random rready, 2 rready pattern 1,0,0,1.
    task automatic axi_read(input logic [6:0] id, input longint addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int rmode,
                            input string tag);
        int t;
        int cyc = 0;
        req.arid = id; req.araddr = addr[31:0]; req.arlen = 8'(len);
        req.arburst = burst; req.arsize = size; req.arvalid = 1'b1;
        t = 0;
        while (!resp.arready && t < 20) begin step(); t++; end
        chk({tag, "/arready"}, resp.arready, 1'b1);
        step();
        req.arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            longint a = beat_addr(addr, b, burst);
            bit ok = beat_ok(a, burst, size);
            logic [511:0] ed = ok ? m_mem[idx_of(a)] : '0;
            int guard = 0;
            while (1) begin
                logic rr;
                if (rmode == 0) rr = 1'b1;
                else if (rmode == 1) rr = 1'($urandom_range(0, 1));
                else rr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                if (guard >= 6) rr = 1'b1;
                req.rready = rr;
                chk({tag, "/rvalid"}, resp.rvalid, 1'b1);
                chk({tag, "/rdata"}, resp.rdata, ed);
                chk({tag, "/rresp"}, resp.rresp, ok ? 2'b00 : 2'b10);
                chk({tag, "/rlast"}, resp.rlast, (b == len));
                chk({tag, "/rid"}, resp.rid, id);
                step();
                cyc++; guard++;
                if (rr) break;
            end
        end
        req.rready = 1'b0;
        chk({tag, "/rvalid_drop"}, resp.rvalid, 1'b0);
        chk({tag, "/arready_back"}, resp.arready, 1'b1);
    endtask

    initial begin
        logic [511:0] d0, d1;
        req = '0;
        rst = 1'b1;
        repeat (2) step();
        // Reset values
        chk("rst/awready", resp.awready, 1'b0);
        chk("rst/wready", resp.wready, 1'b0);
        chk("rst/bvalid", resp.bvalid, 1'b0);
        chk("rst/arready", resp.arready, 1'b0);
        chk("rst/rvalid", resp.rvalid, 1'b0);
        chk("rst/bresp", resp.bresp, 2'b00);
        chk("rst/rresp", resp.rresp, 2'b00);
        chk("rst/rdata", resp.rdata, '0);
        chk("rst/rlast", resp.rlast, 1'b0);
        chk("rst/bid", resp.bid, '0);
        chk("rst/rid", resp.rid, '0);
        rst = 1'b0;
        chk("rel/awready_same", resp.awready, 1'b0);
        step();
        chk("rel/awready", resp.awready, 1'b1);
        chk("rel/arready", resp.arready, 1'b1);

        // Give every word a known value
        fill_w(255, 1'b0, -1);
        axi_write(7'h11, BASE, 255, 2'b01, 3'd6, 0, "fill");

        // INCR write A..D then read back
        fill_w(3, 1'b0, -1);
        for (int b = 0; b < 4; b++) wq_data[b] = {16{32'hA000_0000 + 32'(b)}};
        axi_write(7'h2A, 64'h40, 3, 2'b01, 3'd6, 0, "incr_w");
        axi_read(7'h15, 64'h40, 3, 2'b01, 3'd6, 0, "incr_r");

        // Partial strobe over all-ones
        fill_w(0, 1'b0, -1);
        wq_data[0] = {512{1'b1}};
        axi_write(7'h01, 64'h100, 0, 2'b01, 3'd6, 0, "ff_w");
        fill_w(0, 1'b0, -1);
        wq_data[0] = {64{8'h5A}};
        wq_strb[0] = 64'h0F;
        axi_write(7'h02, 64'h100, 0, 2'b01, 3'd6, 0, "strb_w");
        axi_read(7'h03, 64'h100, 0, 2'b01, 3'd6, 0, "strb_r");

        // Backpressure on R and B
        axi_read(7'h04, 64'h40, 3, 2'b01, 3'd6, 2, "bp_r");
        fill_w(2, 1'b1, -1);
        axi_write(7'h05, 64'h180, 2, 2'b01, 3'd6, 5, "bp_w");
        axi_read(7'h06, 64'h180, 2, 2'b01, 3'd6, 1, "bp_rb");

        // Error cases
        fill_w(1, 1'b0, -1);
        axi_write(7'h07, 64'h80, 1, 2'b10, 3'd6, 0, "wrap_w");
        axi_read(7'h08, 64'h80, 1, 2'b01, 3'd6, 0, "wrap_chk");
        axi_read(7'h09, MEMB - 64, 1, 2'b01, 3'd6, 0, "top_r");
        fill_w(1, 1'b0, -1);
        axi_write(7'h0A, MEMB - 64, 1, 2'b01, 3'd6, 0, "top_w");
        fill_w(1, 1'b0, -1);
        axi_write(7'h0B, 64'h200, 1, 2'b01, 3'd5, 0, "size_w");
        fill_w(3, 1'b0, 1);
        axi_write(7'h0C, 64'h240, 3, 2'b01, 3'd6, 0, "early_last_w");
        fill_w(2, 1'b0, 2);
        axi_write(7'h0D, 64'h2C0, 2, 2'b01, 3'd6, 0, "miss_last_w");
        axi_read(7'h0E, 64'h200, 7, 2'b01, 3'd6, 0, "err_chk");
        axi_read(7'h0F, 64'h40, 2, 2'b10, 3'd6, 0, "wrap_r");
        axi_read(7'h10, 64'h40, 2, 2'b01, 3'd4, 0, "size_r");
        fill_w(2, 1'b1, -1);
        axi_write(7'h12, 64'h3C5, 2, 2'b00, 3'd6, 0, "fixed_w");
        axi_read(7'h13, 64'h3C0, 2, 2'b00, 3'd6, 0, "fixed_r");

        // Reset in the middle of a write burst
        d0 = rand512(); d1 = rand512();
        req.awid = 7'h21; req.awaddr = 32'h200; req.awlen = 8'd3;
        req.awburst = 2'b01; req.awsize = 3'd6; req.awvalid = 1'b1;
        chk("abort/awready", resp.awready, 1'b1);
        step();
        req.awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            req.wdata = b == 0 ? d0 : d1; req.wstrb = {64{1'b1}}; req.wlast = 1'b0;
            req.wvalid = 1'b1;
            chk("abort/wready", resp.wready, 1'b1);
            step();
        end
        m_mem[8] = d0; m_mem[9] = d1;
        rst = 1'b1;
        #1;
        chk("abort/bvalid", resp.bvalid, 1'b0);
        chk("abort/wready_rst", resp.wready, 1'b0);
        chk("abort/awready_rst", resp.awready, 1'b0);
        req.wvalid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("abort/awready_rel", resp.awready, 1'b1);
        chk("abort/bvalid_rel", resp.bvalid, 1'b0);
        fill_w(3, 1'b0, -1);
        axi_write(7'h22, 64'h300, 3, 2'b01, 3'd6, 0, "after_rst_w");
        axi_read(7'h23, 64'h200, 1, 2'b01, 3'd6, 0, "kept_r");
        axi_read(7'h24, 64'h300, 3, 2'b01, 3'd6, 0, "after_rst_r");

        // Concurrent write and read on disjoint regions
        fill_w(3, 1'b1, -1);
        fork
            axi_write(7'h31, 64'h800, 3, 2'b01, 3'd6, 2, "conc_w");
            axi_read(7'h32, 64'h40, 3, 2'b01, 3'd6, 1, "conc_r");
        join
        axi_read(7'h33, 64'h800, 3, 2'b01, 3'd6, 0, "conc_chk");

        // Random bursts
        for (int n = 0; n < 40; n++) begin
            longint a = longint'($urandom_range(0, int'(MEMB) + 256));
            int len = $urandom_range(0, 7);
            int bsel = $urandom_range(0, 9);
            logic [1:0] burst = bsel == 0 ? 2'b00 : (bsel == 1 ? 2'b10 : 2'b01);
            logic [2:0] size = $urandom_range(0, 7) == 0 ? 3'd5 : 3'd6;
            int bad = $urandom_range(0, 7) == 0 ? $urandom_range(0, len) : -1;
            logic [6:0] id = 7'($urandom);
            fill_w(len, 1'b1, bad);
            axi_write(id, a, len, burst, size, $urandom_range(0, 3), "rnd_w");
            axi_read(~id, a, len, burst, size, $urandom_range(0, 2), "rnd_r");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
